// File: rtl/dispatch_queue_pkg.sv
// Shared types for the dispatch queue: register/word types, the queue entry
// record and the occupancy-count width helper.
package dispatch_queue_pkg;

  localparam int PREG_W = 6;
  localparam int WORD_W = 32;

  typedef logic [PREG_W-1:0] p_reg;
  typedef logic [WORD_W-1:0] word;

  typedef struct packed {
    logic valid;
    p_reg src1;
    logic src1_rdy;
    p_reg src2;
    logic src2_rdy;
    p_reg dst;
    word  payload;
  } dq_entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Dispatch, wakeup and issue bundle between rename/regread, the queue and
// the execute units. The queue side uses the slave modport.
interface dispatch_queue_if import dispatch_queue_pkg::*; #(
  parameter int DEPTH          = 8,
  parameter int DISPATCH_WIDTH = 2,
  parameter int WAKEUP_PORTS   = 2
) ();

  localparam int CNT_W = count_width(DEPTH);

  logic                      i_flush;
  logic [DISPATCH_WIDTH-1:0] i_disp_valid;
  p_reg                      i_disp_src1     [DISPATCH_WIDTH];
  p_reg                      i_disp_src2     [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH-1:0] i_disp_src1_rdy;
  logic [DISPATCH_WIDTH-1:0] i_disp_src2_rdy;
  p_reg                      i_disp_dst      [DISPATCH_WIDTH];
  word                       i_disp_payload  [DISPATCH_WIDTH];
  logic                      o_disp_ready;
  logic [WAKEUP_PORTS-1:0]   i_wb_valid;
  p_reg                      i_wb_tag        [WAKEUP_PORTS];
  logic                      o_issue_valid;
  logic                      i_issue_ready;
  p_reg                      o_issue_src1;
  p_reg                      o_issue_src2;
  p_reg                      o_issue_dst;
  word                       o_issue_payload;
  logic [CNT_W-1:0]          o_count;

  modport slave (
    input  i_flush, i_disp_valid, i_disp_src1, i_disp_src2, i_disp_src1_rdy,
           i_disp_src2_rdy, i_disp_dst, i_disp_payload, i_wb_valid, i_wb_tag,
           i_issue_ready,
    output o_disp_ready, o_issue_valid, o_issue_src1, o_issue_src2,
           o_issue_dst, o_issue_payload, o_count
  );

  modport master (
    output i_flush, i_disp_valid, i_disp_src1, i_disp_src2, i_disp_src1_rdy,
           i_disp_src2_rdy, i_disp_dst, i_disp_payload, i_wb_valid, i_wb_tag,
           i_issue_ready,
    input  o_disp_ready, o_issue_valid, o_issue_src1, o_issue_src2,
           o_issue_dst, o_issue_payload, o_count
  );

endinterface

// File: rtl/dispatch_queue_select.sv
// Oldest-ready picker: one-hot grant on the lowest set request bit.
module dq_select #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant,
  output logic         o_found
);

  logic w_taken;

  always_comb begin
    o_grant = '0;
    w_taken = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i] && !w_taken) begin
        o_grant[i] = 1'b1;
        w_taken    = 1'b1;
      end
    end
    o_found = w_taken;
  end

endmodule

// File: rtl/dispatch_queue.sv
// Age-ordered collapsing issue queue with tag wakeup. Slot 0 is the oldest;
// valid entries are kept contiguous from slot 0.
module dispatch_queue import dispatch_queue_pkg::*; #(
  parameter int DEPTH          = 8,
  parameter int DISPATCH_WIDTH = 2,
  parameter int WAKEUP_PORTS   = 2
) (
  input logic             i_clk,
  input logic             i_rst,
  dispatch_queue_if.slave io
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  dq_entry_t        r_slot   [DEPTH];
  logic [CNT_W-1:0] r_count;

  dq_entry_t        w_woken  [DEPTH];
  dq_entry_t        w_lane   [DISPATCH_WIDTH];
  dq_entry_t        w_next   [DEPTH];
  dq_entry_t        w_sel;
  logic [CNT_W-1:0] w_count_next;
  logic [DEPTH-1:0] w_req;
  logic [DEPTH-1:0] w_grant;
  logic             w_found;
  logic             w_issue;
  logic             w_disp_ready;
  logic             w_shift;
  int               w_pos;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      w_req[i] = r_slot[i].valid & r_slot[i].src1_rdy & r_slot[i].src2_rdy;
  end

  dq_select #(.N(DEPTH)) u_select (
    .i_req   (w_req),
    .o_grant (w_grant),
    .o_found (w_found)
  );

  // Grant is one-hot, so a priority mux is equivalent to an AND-OR mux here.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_grant[i]) w_sel = r_slot[i];
  end

  assign w_disp_ready = (DEPTH - int'(r_count)) >= DISPATCH_WIDTH;
  assign w_issue      = w_found & io.i_issue_ready;

  assign io.o_disp_ready    = w_disp_ready;
  assign io.o_issue_valid   = w_found;
  assign io.o_issue_src1    = w_sel.src1;
  assign io.o_issue_src2    = w_sel.src2;
  assign io.o_issue_dst     = w_sel.dst;
  assign io.o_issue_payload = w_sel.payload;
  assign io.o_count         = r_count;

  // NOTE: combinational next-state uses blocking '=' so later statements see
  // earlier results (wakeup -> compaction -> append); only the register
  // process below uses '<='.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woken[i] = r_slot[i];
      for (int k = 0; k < WAKEUP_PORTS; k++) begin
        if (io.i_wb_valid[k] && r_slot[i].valid) begin
          if (io.i_wb_tag[k] == r_slot[i].src1) w_woken[i].src1_rdy = 1'b1;
          if (io.i_wb_tag[k] == r_slot[i].src2) w_woken[i].src2_rdy = 1'b1;
        end
      end
    end

    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      w_lane[l].valid    = 1'b1;
      w_lane[l].src1     = io.i_disp_src1[l];
      w_lane[l].src2     = io.i_disp_src2[l];
      w_lane[l].dst      = io.i_disp_dst[l];
      w_lane[l].payload  = io.i_disp_payload[l];
      w_lane[l].src1_rdy = io.i_disp_src1_rdy[l];
      w_lane[l].src2_rdy = io.i_disp_src2_rdy[l];
      for (int k = 0; k < WAKEUP_PORTS; k++) begin
        if (io.i_wb_valid[k] && io.i_wb_tag[k] == io.i_disp_src1[l]) w_lane[l].src1_rdy = 1'b1;
        if (io.i_wb_valid[k] && io.i_wb_tag[k] == io.i_disp_src2[l]) w_lane[l].src2_rdy = 1'b1;
      end
    end

    // Everything at or above the issued slot moves down by one.
    w_shift = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_shift   = w_shift | (w_issue & w_grant[i]);
      w_next[i] = w_shift ? w_woken[i+1] : w_woken[i];
    end
    w_shift           = w_shift | (w_issue & w_grant[DEPTH-1]);
    w_next[DEPTH-1]   = w_shift ? '0 : w_woken[DEPTH-1];

    w_pos = int'(r_count) - int'(w_issue);
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (w_disp_ready && io.i_disp_valid[l] && w_pos < DEPTH) begin
        w_next[IDX_W'(w_pos)] = w_lane[l];
        w_pos = w_pos + 1;
      end
    end
    w_count_next = CNT_W'(w_pos);

    if (io.i_flush) begin
      for (int i = 0; i < DEPTH; i++) w_next[i] = '0;
      w_count_next = '0;
    end
  end

  // NOTE: the slot array is reset in full, not just the valid bits, so the
  // combinational issue fields read zero out of reset instead of X.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_count <= '0;
    end else begin
      r_slot  <= w_next;
      r_count <= w_count_next;
    end
  end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised, multi-lane successor to the single-entry dispatch register. It sits between rename/register-read and the execute units. It accepts up to DISPATCH_WIDTH renamed micro-ops per cycle, holds them in an age-ordered collapsing buffer, and wakes operands by matching physical-register tags broadcast on the writeback ports. Each cycle it issues the oldest entry whose sources are both ready.

## Interface
- DEPTH, 8, number of entries; must be at least DISPATCH_WIDTH.
- DISPATCH_WIDTH, 2, number of dispatch lanes per cycle.
- WAKEUP_PORTS, 2, number of writeback tag broadcast ports.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  synchronous clear of all entries.
- i_disp_valid  in  [DISPATCH_WIDTH]  per-lane dispatch request.
- i_disp_src1, i_disp_src2  in  [DISPATCH_WIDTH] x p_reg  source physical registers.
- i_disp_src1_rdy, i_disp_src2_rdy  in  [DISPATCH_WIDTH]  source already ready at dispatch (scoreboard).
- i_disp_dst  in  [DISPATCH_WIDTH] x p_reg  destination physical register.
- i_disp_payload  in  [DISPATCH_WIDTH] x word  opaque op/immediate bundle.
- o_disp_ready  out  1  all lanes may be accepted this cycle.
- i_wb_valid  in  [WAKEUP_PORTS]  wakeup broadcast valid.
- i_wb_tag  in  [WAKEUP_PORTS] x p_reg  completed destination tag.
- o_issue_valid  out  1  an entry is selected for issue.
- i_issue_ready  in  1  execute unit accepts.
- o_issue_src1, o_issue_src2, o_issue_dst  out  p_reg  fields of the issuing entry.
- o_issue_payload  out  word  payload of the issuing entry.
- o_count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is slot[0..DEPTH-1], with slot 0 the oldest. Valid entries are always contiguous from slot 0, and o_count equals the number of valid entries.
- **Dispatch**
  - o_disp_ready = (DEPTH - o_count) >= DISPATCH_WIDTH. It uses the registered count only; a same-cycle issue earns no credit.
  - On o_disp_ready, valid lanes are appended in lane-index order after the compacted tail. Invalid lanes are skipped, so a valid lane 1 with an invalid lane 0 lands at the tail.
  - Lanes asserted while o_disp_ready=0 are dropped, and the upstream stage must hold them.
- **Wakeup**
  - Each cycle, every valid entry sets src*_rdy when any i_wb_valid[k] has a matching i_wb_tag[k].
  - Dispatching lanes also compare against the same-cycle wakeup tags. The stored rdy is the OR of the incoming rdy and any tag match, so no wakeup is lost.
  - Ready bits only ever set; they never clear.
- **Select**
  - The issue candidate is the lowest-index valid entry with src1_rdy and src2_rdy.
  - Selection uses registered state only, and the o_issue_* outputs are combinational from it.
- **Issue**
  - On o_issue_valid && i_issue_ready, the selected slot is removed. Younger entries shift down by one, then new lanes append.
  - If o_issue_valid is high and i_issue_ready is low, nothing is removed and the selection may change next cycle.
- **Flush**
  - Clears all valid bits and sets count to 0.
  - Takes priority over dispatch and issue in the same cycle; dispatched lanes are discarded.
- **Count update:** next = count - issued + accepted lanes, where issued is 0 or 1.

## Timing
- Reset values: all entries invalid, o_count=0, o_disp_ready=1, o_issue_valid=0. Other o_issue_* fields read 0.
- Reset asserted mid-operation empties the queue immediately; no pending entry survives.
- Dispatch-to-issue latency is 1 cycle minimum: dispatched with both sources ready at edge N gives o_issue_valid from N+1.
- A wakeup at edge N makes the entry issuable from N+1.
- Full: o_disp_ready=0 when free slots < DISPATCH_WIDTH, including partially free.
- Empty: o_issue_valid=0.
- Simultaneous issue and dispatch in one cycle is legal and exact: compaction first, then append.

## Structure
- Types package gains:
  - dq_entry_t: valid, src1, src1_rdy, src2, src2_rdy, dst (p_reg), payload (word).
  - The count width function.
- p_reg and word are reused unchanged.
- One sub-module, dq_select: combinational oldest-ready priority picker. It takes a DEPTH-bit ready vector and returns a one-hot grant plus a found flag. The parent owns all state, compaction and wakeup CAM.

## Test plan
All scenarios use DEPTH=8, DISPATCH_WIDTH=2, WAKEUP_PORTS=2.
1. Reset: after i_rst, check o_count=0, o_disp_ready=1, o_issue_valid=0. Then assert i_rst mid-stream with 5 entries → all cleared in the same cycle.
2. Ready at dispatch:
   - Dispatch lane0 with dst=p5, both rdy → issue at the next edge with o_issue_dst=5.
   - Dispatch lane0 not ready (src1=p9) and lane1 ready → lane1 issues first.
3. Wakeup:
   - Entry waiting on src1=p9 and src2=p10; broadcast p9 on port0 and p10 on port1 at edge N → o_issue_valid at N+1.
   - Same-cycle dispatch with src1=p9 while p9 is broadcast → entry stored ready.
4. Fill/full: dispatch 2 lanes for 4 cycles with nothing ready → o_count=8, o_disp_ready=0. Issue one → o_count=7, o_disp_ready still 0. Issue two → o_count=6, o_disp_ready=1.
5. Age order and compaction:
   - Entries A..E with C, then A, made ready → A issues before C.
   - Remaining order is B, D, E behind C.
   - Concurrent issue plus 2-lane dispatch keeps o_count exact.
6. Flush and backpressure:
   - Hold i_issue_ready=0 for 3 cycles → the entry stays and o_issue_* are stable.
   - i_flush together with a dispatch → o_count=0 next cycle, nothing issues.
